// File: rtl/vme_pkg.sv
// rtl/vme_pkg.sv - shared constants and FSM state encoding for the VME IACK cycle master
package vme_pkg;

  // VME IACK level is carried on A3:A1
  localparam int LEVEL_W         = 3;
  localparam int DEFAULT_TIMEOUT = 1024;
  localparam int DEFAULT_SETTLE  = 2;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETUP    = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_ACK = 3'd2;
  localparam logic [STATE_W-1:0] ST_RELEASE  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DELIVER  = 3'd4;

endpackage

// File: rtl/vme_sync2.sv
// rtl/vme_sync2.sv - two-flop synchronizer for asynchronous VME strobes
module vme_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  // shift the raw input through two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // strobes idle deasserted (high) out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/vme_iack_cycle_ctrl.sv
// rtl/vme_iack_cycle_ctrl.sv - VME interrupt-acknowledge cycle master with status/ID capture
module vme_iack_cycle_ctrl
  import vme_pkg::*;
#(
  parameter int SETTLE_CYCLES  = DEFAULT_SETTLE,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int VEC_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 irq,
  input  logic [LEVEL_W-1:0]   vec_addr,
  output logic                 vme_iack_n,
  output logic                 vme_as_n,
  output logic                 vme_ds0_n,
  output logic [LEVEL_W-1:0]   vme_addr,
  input  logic                 vme_dtack_n,
  input  logic                 vme_berr_n,
  input  logic [VEC_WIDTH-1:0] vme_data,
  output logic                 iack,
  output logic                 dtack,
  output logic [VEC_WIDTH-1:0] vector,
  output logic                 vector_valid,
  output logic                 vector_err,
  input  logic                 vector_ack
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  // synced active-low copies; the FSM never looks at the raw bus lines
  logic dtk;
  logic berr;

  vme_sync2 #(.RESET_VAL(1'b1)) u_sync_dtack (
    .clk   (clk),
    .reset (reset),
    .d     (vme_dtack_n),
    .q     (dtk)
  );

  vme_sync2 #(.RESET_VAL(1'b1)) u_sync_berr (
    .clk   (clk),
    .reset (reset),
    .d     (vme_berr_n),
    .q     (berr)
  );

  logic [STATE_W-1:0]   state_d, state_q;
  logic [3:0]           settle_cnt_d, settle_cnt_q;
  logic [TW-1:0]        timer_d, timer_q;
  logic                 iack_n_d, iack_n_q;
  logic                 as_n_d, as_n_q;
  logic                 ds0_n_d, ds0_n_q;
  logic [LEVEL_W-1:0]   addr_d, addr_q;
  logic                 iack_d, iack_q;
  logic                 dtack_d, dtack_q;
  logic [VEC_WIDTH-1:0] vector_d, vector_q;
  logic                 valid_d, valid_q;
  logic                 err_d, err_q;
  logic [TW-1:0]        timer_inc;

  // the timer sticks at its last value rather than wrapping
  assign timer_inc = (timer_q == TIMER_LAST) ? timer_q : timer_q + TIMER_ONE;

  // IACK cycle sequencing: address/IACK setup, strobe, capture, release, hand-off
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    timer_d      = timer_q;
    iack_n_d     = iack_n_q;
    as_n_d       = as_n_q;
    ds0_n_d      = ds0_n_q;
    addr_d       = addr_q;
    iack_d       = iack_q;
    dtack_d      = 1'b0;
    vector_d     = vector_q;
    valid_d      = valid_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        // a vector still awaiting the CPU blocks any new acknowledge
        if (irq && !valid_q) begin
          addr_d       = vec_addr;
          iack_n_d     = 1'b0;
          iack_d       = 1'b1;
          settle_cnt_d = '0;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // irq is not rechecked here: once started, the cycle runs to completion
        if (settle_cnt_q == SETTLE_LAST) begin
          as_n_d       = 1'b0;
          ds0_n_d      = 1'b0;
          timer_d      = '0;
          settle_cnt_d = '0;
          state_d      = ST_WAIT_ACK;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      ST_WAIT_ACK: begin
        // DTACK is checked first so it wins over a simultaneous BERR or timeout
        if (!dtk) begin
          vector_d = vme_data;
          err_d    = 1'b0;
          dtack_d  = 1'b1;
          as_n_d   = 1'b1;
          ds0_n_d  = 1'b1;
          timer_d  = '0;
          state_d  = ST_RELEASE;
        end else if (!berr || timer_q == TIMER_LAST) begin
          vector_d = '0;
          err_d    = 1'b1;
          dtack_d  = 1'b1;
          as_n_d   = 1'b1;
          ds0_n_d  = 1'b1;
          timer_d  = '0;
          state_d  = ST_RELEASE;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_RELEASE: begin
        // keep IACK* low until the interrupter lets go; a stuck line only costs a timeout
        if ((dtk && berr) || timer_q == TIMER_LAST) begin
          iack_n_d = 1'b1;
          iack_d   = 1'b0;
          valid_d  = 1'b1;
          timer_d  = '0;
          state_d  = ST_DELIVER;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_DELIVER: begin
        if (vector_ack) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // asynchronous reset drops every VME strobe immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      timer_q      <= '0;
      iack_n_q     <= 1'b1;
      as_n_q       <= 1'b1;
      ds0_n_q      <= 1'b1;
      addr_q       <= '0;
      iack_q       <= 1'b0;
      dtack_q      <= 1'b0;
      vector_q     <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      timer_q      <= timer_d;
      iack_n_q     <= iack_n_d;
      as_n_q       <= as_n_d;
      ds0_n_q      <= ds0_n_d;
      addr_q       <= addr_d;
      iack_q       <= iack_d;
      dtack_q      <= dtack_d;
      vector_q     <= vector_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign vme_iack_n   = iack_n_q;
  assign vme_as_n     = as_n_q;
  assign vme_ds0_n    = ds0_n_q;
  assign vme_addr     = addr_q;
  assign iack         = iack_q;
  assign dtack        = dtack_q;
  assign vector       = vector_q;
  assign vector_valid = valid_q;
  assign vector_err   = err_q;

endmodule
